// File: rtl/sorting_pkg.sv
// Shared types and constants for the streaming sorting engine.
package sorting_pkg;

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  localparam logic SORT_ASC  = 1'b0;
  localparam logic SORT_DESC = 1'b1;

endpackage

// File: rtl/sort_cell.sv
// One slot of the ordered register array: hold, shift in from the slot below, or load new.
module sort_cell #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] nbr_i,
  input  logic [DATA_W-1:0] new_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = new_i;
    end else if (shift_i) begin
      q_d = nbr_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/sorting_engine.sv
// Streaming insertion sorter: loads a batch one beat per clock, then drains it in order.
// Optional SORT_DEDUP_EN discards beats equal to an already stored element.
module sorting_engine
  import sorting_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              sort_type_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  input  logic              out_ready_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d, rd_ptr_q, rd_ptr_d, ins_pos;
  logic              overflow_q, overflow_d, dir_q, dir_d, dir_eff;
  logic              accept, full, dup, store, last_beat;
  logic [DATA_W-1:0] slot [DEPTH];

  assign accept  = in_valid_i && (state_q == ST_LOAD);
  assign full    = (count_q == CNT_W'(DEPTH));
  // The first beat of a batch must already be sorted by its own sort_type.
  assign dir_eff = (count_q == '0) ? sort_type_i : dir_q;
  assign store   = accept && !full && !dup;

  // Stored slots are ordered, so the preceding elements form a prefix.
  always_comb begin
    ins_pos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        if ((dir_eff == SORT_ASC) ? (slot[i] <= in_data_i) : (slot[i] >= in_data_i)) begin
          ins_pos = ins_pos + CNT_W'(1);
        end
      end
    end
  end

`ifdef SORT_DEDUP_EN
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) && (slot[i] == in_data_i)) begin
        dup = 1'b1;
      end
    end
  end
`else
  assign dup = 1'b0;
`endif

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    logic [DATA_W-1:0] nbr;
    if (g == 0) begin : g_first
      assign nbr = '0;
    end else begin : g_rest
      assign nbr = slot[g-1];
    end

    sort_cell #(
      .DATA_W(DATA_W)
    ) u_cell (
      .clk_i   (clk_i),
      .reset_ni(reset_ni),
      .load_i  (store && (ins_pos == CNT_W'(g))),
      .shift_i (store && (ins_pos < CNT_W'(g)) && (CNT_W'(g) <= count_q)),
      .nbr_i   (nbr),
      .new_i   (in_data_i),
      .q_o     (slot[g])
    );
  end

  assign last_beat = ((rd_ptr_q + CNT_W'(1)) == count_q);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    dir_d       = dir_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_last_o  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        in_ready_o = 1'b1;
        if (accept) begin
          if (count_q == '0) begin
            dir_d = sort_type_i;
          end
          if (store) begin
            count_d = count_q + CNT_W'(1);
          end else if (!dup) begin
            overflow_d = 1'b1;
          end
          if (in_last_i) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        out_valid_o = 1'b1;
        out_last_o  = last_beat;
        for (int i = 0; i < DEPTH; i++) begin
          if (rd_ptr_q == CNT_W'(i)) begin
            out_data_o = slot[i];
          end
        end
        if (out_ready_i) begin
          if (last_beat) begin
            state_d    = ST_LOAD;
            count_d    = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
          end else begin
            rd_ptr_d = rd_ptr_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_LOAD;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      dir_q      <= SORT_ASC;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      dir_q      <= dir_d;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_sorting_engine.sv
// Scoreboard bench for sorting_engine: a value-ordered reference model feeds an expectation queue.
module tb_sorting_engine;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int          NVAL   = 1 << DATA_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              sort_type = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              out_ready = 1'b1;
  logic              in_ready, out_valid, out_last, overflow;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;
  int rdy_phase = 0;
  int n_out = 0;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] stim_q[$];

  always #5 clk = ~clk;

  sorting_engine #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .sort_type_i(sort_type),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_last_i  (in_last),
    .in_ready_o (in_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_last_o (out_last),
    .out_ready_i(out_ready),
    .count_o    (count),
    .overflow_o (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // out_ready: 0 = always ready, 1 = pattern 1,0,0,1, otherwise random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((rdy_phase % 4) == 0) || ((rdy_phase % 4) == 3);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    rdy_phase++;
  end

  // Monitor: every presented beat is compared to the queue head, so stalls also check hold.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      check("in_ready_during_drain", in_ready, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data %0d, expected no output", out_data);
      end else begin
        check("out_data", out_data, exp_q[0].data);
        check("out_last", out_last, exp_q[0].last);
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_out++;
        end
      end
    end
  end

  task automatic run_batch(input bit dir, input bit toggle, input int mode, input int abort_after);
    logic [DATA_W-1:0] kept[$];
    exp_t              exp_local[$];
    bit                ovf;
    int                c;
    ovf = 1'b0;
    // Reference: stored multiset, then emit by value order; equal keys are indistinguishable.
    foreach (stim_q[i]) begin
`ifdef SORT_DEDUP_EN
      bit seen;
      seen = 1'b0;
      foreach (kept[j]) if (kept[j] == stim_q[i]) seen = 1'b1;
      if (seen) continue;
`endif
      if (kept.size() == DEPTH) ovf = 1'b1;
      else kept.push_back(stim_q[i]);
    end
    for (int k = 0; k < NVAL; k++) begin
      int v;
      v = dir ? (NVAL - 1 - k) : k;
      foreach (kept[j]) begin
        if (int'(kept[j]) == v) begin
          exp_t e;
          e.data = v[DATA_W-1:0];
          e.last = (exp_local.size() == kept.size() - 1);
          exp_local.push_back(e);
        end
      end
    end

    rdy_mode = mode;
    n_out = 0;
    for (int i = 0; i < stim_q.size(); i++) begin
      in_valid  = 1'b1;
      in_data   = stim_q[i];
      in_last   = (i == stim_q.size() - 1);
      sort_type = (toggle && i > 0) ? 1'($urandom_range(0, 1)) : dir;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    foreach (exp_local[i]) exp_q.push_back(exp_local[i]);
    check("count_after_load", count, kept.size());
    check("overflow_after_load", overflow, ovf);

    if (abort_after > 0) begin
      c = 0;
      while (n_out < abort_after && c < 200) begin
        @(posedge clk);
        #1;
        c++;
      end
      if (n_out < abort_after) begin
        checks++;
        errors++;
        $display("FAIL abort_wait_timeout: got %0d outputs, expected %0d", n_out, abort_after);
      end
      reset_n = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_count", count, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_overflow", overflow, 0);
      check("rst_out_data", out_data, 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      return;
    end

    c = 0;
    while (exp_q.size() != 0 && c < 4 * DEPTH + 20) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats left, expected 0", exp_q.size());
      exp_q.delete();
    end
    check("in_ready_after_drain", in_ready, 1);
    check("count_after_drain", count, 0);
    check("overflow_after_drain", overflow, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] base[$];
    base = '{121, 37, 11, 45, 246, 83, 180, 233, 96, 242, 104, 63, 3, 157, 28};

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_last", out_last, 0);
    check("reset_out_data", out_data, 0);
    check("reset_count", count, 0);
    check("reset_overflow", overflow, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_release", in_ready, 1);

    stim_q = base;
    run_batch(1'b0, 1'b0, 0, 0);
    stim_q = base;
    run_batch(1'b1, 1'b1, 0, 0);

    stim_q.delete();
    for (int v = 20; v >= 3; v--) stim_q.push_back(v[DATA_W-1:0]);
    run_batch(1'b0, 1'b0, 0, 0);

    stim_q = base;
    run_batch(1'b0, 1'b0, 1, 0);

    stim_q = '{7, 7, 3, 7};
    run_batch(1'b0, 1'b0, 1, 0);

    stim_q = base;
    run_batch(1'b0, 1'b0, 0, 4);
    stim_q = '{9, 1};
    run_batch(1'b0, 1'b0, 0, 0);

    for (int b = 0; b < 25; b++) begin
      int len;
      bit narrow;
      len    = $urandom_range(1, DEPTH + 4);
      narrow = 1'($urandom_range(0, 1));
      stim_q.delete();
      for (int i = 0; i < len; i++) begin
        stim_q.push_back(narrow ? DATA_W'($urandom_range(0, 7)) : DATA_W'($urandom_range(0, 255)));
      end
      run_batch(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
